// File: rtl/divider_pkg.sv
// Shared FSM encoding for the sequential signed divider.
package divider_pkg;
  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;
endpackage

// File: rtl/divider_div_step.sv
// One restoring-division step: shift in a dividend bit, trial-subtract the divisor.
module div_step #(
  parameter int N = 5
) (
  input  logic [N-1:0] rem_in,
  input  logic         bit_in,
  input  logic [N-1:0] divisor,
  output logic [N-1:0] rem_out,
  output logic         q_bit
);
  logic [N:0] shifted;
  logic [N:0] diff;

  always_comb begin
    shifted = {rem_in, bit_in};
    diff    = shifted - {1'b0, divisor};
    // A clear top bit means the trial subtraction did not borrow.
    q_bit   = ~diff[N];
    rem_out = q_bit ? diff[N-1:0] : shifted[N-1:0];
  end
endmodule

// File: rtl/divider.sv
// Multi-cycle signed divider: magnitudes divided by restoring steps, signs fixed afterwards.
module divider
  import divider_pkg::*;
#(
  parameter int N = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_by_zero,
  output logic         overflow
);
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(N - 1);
  localparam logic [N-1:0] MIN_VAL = {1'b1, {(N-1){1'b0}}};

  function automatic logic [N-1:0] neg(input logic [N-1:0] x);
    return ~x + 1'b1;
  endfunction

  function automatic logic [N-1:0] mag(input logic [N-1:0] x);
    return x[N-1] ? neg(x) : x;
  endfunction

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N-1:0]     a_q, a_d;
  logic             a_neg_q, a_neg_d;
  logic             b_neg_q, b_neg_d;
  logic [N-1:0]     bmag_q, bmag_d;
  logic [N-1:0]     rem_q, rem_d;
  logic [N-1:0]     aq_q, aq_d;
  logic             dbz_pend_q, dbz_pend_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic [N-1:0]     quotient_q, quotient_d;
  logic [N-1:0]     remainder_q, remainder_d;
  logic             dbz_q, dbz_d;
  logic             ovf_q, ovf_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic [N-1:0]     step_rem;
  logic             step_q;

  div_step #(.N(N)) u_step (
    .rem_in  (rem_q),
    .bit_in  (aq_q[N-1]),
    .divisor (bmag_q),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    a_neg_d     = a_neg_q;
    b_neg_d     = b_neg_q;
    bmag_d      = bmag_q;
    rem_d       = rem_q;
    aq_d        = aq_q;
    dbz_pend_d  = dbz_pend_q;
    ovf_pend_d  = ovf_pend_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    ovf_d       = ovf_q;
    busy_d      = busy_q;
    done_d      = done_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_d        = dividend;
          a_neg_d    = dividend[N-1];
          b_neg_d    = divisor[N-1];
          bmag_d     = mag(divisor);
          aq_d       = mag(dividend);
          rem_d      = '0;
          cnt_d      = '0;
          dbz_pend_d = (divisor == '0);
          ovf_pend_d = (dividend == MIN_VAL) && (divisor == '1);
          busy_d     = 1'b1;
          state_d    = (divisor == '0) ? FIX : CALC;
        end
      end
      CALC: begin
        // Quotient bits shift into the low end as dividend bits leave the top.
        rem_d = step_rem;
        aq_d  = {aq_q[N-2:0], step_q};
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_ITER) begin
          cnt_d   = '0;
          state_d = FIX;
        end
      end
      FIX: begin
        if (dbz_pend_q) begin
          quotient_d  = '1;
          remainder_d = a_q;
        end else begin
          quotient_d  = (a_neg_q ^ b_neg_q) ? neg(aq_q) : aq_q;
          remainder_d = a_neg_q ? neg(rem_q) : rem_q;
        end
        dbz_d   = dbz_pend_q;
        ovf_d   = ovf_pend_q;
        done_d  = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      a_neg_q     <= 1'b0;
      b_neg_q     <= 1'b0;
      bmag_q      <= '0;
      rem_q       <= '0;
      aq_q        <= '0;
      dbz_pend_q  <= 1'b0;
      ovf_pend_q  <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      a_neg_q     <= a_neg_d;
      b_neg_q     <= b_neg_d;
      bmag_q      <= bmag_d;
      rem_q       <= rem_d;
      aq_q        <= aq_d;
      dbz_pend_q  <= dbz_pend_d;
      ovf_pend_q  <= ovf_pend_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
      ovf_q       <= ovf_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
  assign overflow    = ovf_q;
endmodule

// File: doc/divider.md
DIVIDER -- requirements
Module: divider

Interface
REQ-001 SHALL have parameter N, default 5, meaning operand/result width in bits (two's complement).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start  input  1  request a division; sampled only in IDLE.
REQ-005 SHALL have port dividend  input  N  signed dividend A; captured on accepted start.
REQ-006 SHALL have port divisor  input  N  signed divisor B; captured on accepted start.
REQ-007 SHALL have port busy  output  1  high while a division is in progress.
REQ-008 SHALL have port done  output  1  one-cycle pulse: results valid.
REQ-009 SHALL have port quotient  output  N  signed A/B, truncated toward zero.
REQ-010 SHALL have port remainder  output  N  signed A - B*quotient; sign follows dividend.
REQ-011 SHALL have port div_by_zero  output  1  last result came from B == 0.
REQ-012 SHALL have port overflow  output  1  last result came from A == -2^(N-1), B == -1.

Function
REQ-013 SHALL implement states IDLE, CALC, FIX, DONE; IDLE->CALC on start, CALC->FIX after N iterations, FIX->DONE, DONE->IDLE unconditionally.
REQ-014 SHALL, on start in IDLE, capture A and B, record both signs, load |A| and |B| as N-bit unsigned magnitudes (|-2^(N-1)| = 2^(N-1)).
REQ-015 SHALL perform one restoring shift/subtract step per CALC cycle, iteration counter counting 0..N-1.
REQ-016 SHALL in FIX negate the quotient magnitude if sign(A) != sign(B), negate the remainder magnitude if A < 0, and register quotient/remainder.
REQ-017 SHALL assert done for exactly the single DONE cycle; latency from the accepting edge to done high is N+2 cycles.
REQ-018 SHALL hold busy high from the cycle after the accepting edge through the DONE cycle inclusive.
REQ-019 SHALL ignore start whenever not in IDLE; operand changes during busy SHALL NOT affect the result.
REQ-020 SHALL, when B == 0, skip CALC (IDLE->FIX->DONE), producing quotient = all ones (-1), remainder = A, div_by_zero = 1; done two cycles after accept.
REQ-021 SHALL, when A == -2^(N-1) and B == -1, produce quotient = -2^(N-1) (wrapped), remainder = 0, overflow = 1, using the normal N+2 latency.
REQ-022 SHALL hold quotient, remainder, div_by_zero and overflow stable from done until the FIX cycle of the next accepted division.
REQ-023 SHALL accept start on the cycle directly after DONE (back-to-back operation permitted).

Reset
REQ-024 SHALL on rst_n low immediately force state = IDLE, busy = 0, done = 0, quotient = 0, remainder = 0, div_by_zero = 0, overflow = 0, counter = 0.
REQ-025 SHALL on reset asserted mid-division abandon the operation with no done pulse; first start after rst_n release SHALL be accepted normally.

Structure
REQ-026 SHALL place the state enumeration and state-width constant in shared package divider_pkg.
REQ-027 SHALL instantiate one combinational sub-module div_step (N-bit partial remainder, dividend bit, divisor in -> next partial remainder, quotient bit out).
REQ-028 SHALL contain no multipliers or division operators; arithmetic is add/subtract/shift only.

Verification (N = 5)
REQ-029 SHALL check A=-10 (10110), B=4 (00100) -> quotient=-2 (11110), remainder=-2 (11110), done 7 cycles after accept, flags 0.
REQ-030 SHALL check A=11 (01011), B=-3 (11101) -> quotient=-3 (11101), remainder=2 (00010).
REQ-031 SHALL check A=-10 (10110), B=-11 (10101) -> quotient=0, remainder=-10 (10110); start pulsed while busy with other operands -> ignored, result unchanged.
REQ-032 SHALL check A=7, B=0 -> quotient=11111, remainder=00111, div_by_zero=1, done 2 cycles after accept.
REQ-033 SHALL check A=-16 (10000), B=-1 (11111) -> quotient=10000, remainder=0, overflow=1.
REQ-034 SHALL check rst_n pulsed low during CALC of 15/2 -> no done, all outputs 0; following 15/2 -> quotient=7, remainder=1.
